// File: rtl/esp_dma32_mem_responder_if.sv
// DMA channel bundle between the OBI-to-ESP bridge (master) and the memory
// responder (slave): read/write command channels plus read/write data channels.
interface esp_dma32_mem_responder_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  dma_read_ctrl_valid;
  logic                  dma_read_ctrl_ready;
  logic [31:0]           dma_read_ctrl_data_index;
  logic [31:0]           dma_read_ctrl_data_length;
  logic [2:0]            dma_read_ctrl_data_size;

  logic                  dma_read_chnl_valid;
  logic                  dma_read_chnl_ready;
  logic [DATA_WIDTH-1:0] dma_read_chnl_data;

  logic                  dma_write_ctrl_valid;
  logic                  dma_write_ctrl_ready;
  logic [31:0]           dma_write_ctrl_data_index;
  logic [31:0]           dma_write_ctrl_data_length;
  logic [2:0]            dma_write_ctrl_data_size;

  logic                  dma_write_chnl_valid;
  logic                  dma_write_chnl_ready;
  logic [DATA_WIDTH-1:0] dma_write_chnl_data;

  modport master (
    output dma_read_ctrl_valid, dma_read_ctrl_data_index,
           dma_read_ctrl_data_length, dma_read_ctrl_data_size,
    input  dma_read_ctrl_ready,
    input  dma_read_chnl_valid, dma_read_chnl_data,
    output dma_read_chnl_ready,
    output dma_write_ctrl_valid, dma_write_ctrl_data_index,
           dma_write_ctrl_data_length, dma_write_ctrl_data_size,
    input  dma_write_ctrl_ready,
    output dma_write_chnl_valid, dma_write_chnl_data,
    input  dma_write_chnl_ready
  );

  modport slave (
    input  dma_read_ctrl_valid, dma_read_ctrl_data_index,
           dma_read_ctrl_data_length, dma_read_ctrl_data_size,
    output dma_read_ctrl_ready,
    output dma_read_chnl_valid, dma_read_chnl_data,
    input  dma_read_chnl_ready,
    input  dma_write_ctrl_valid, dma_write_ctrl_data_index,
           dma_write_ctrl_data_length, dma_write_ctrl_data_size,
    output dma_write_ctrl_ready,
    input  dma_write_chnl_valid, dma_write_chnl_data,
    output dma_write_chnl_ready
  );
endinterface

// File: rtl/esp_dma32_mem_responder.sv
// ESP DMA target: services read/write bursts from the OBI-to-ESP bridge against a
// word-addressed SRAM port with 1-cycle read latency, through a 2-entry read FIFO.
module esp_dma32_mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  esp_dma32_mem_responder_if.slave dma,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    size_err_o
);

  localparam logic [2:0] SIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  last_wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           rem_q;

  logic [DATA_WIDTH-1:0] fifo_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            fifo_cnt_q, fifo_cnt_d;
  logic                  inflight_q;

  logic                  grant_rd, grant_wr;
  logic                  rd_issue, rd_pop, wr_fire, wr_chnl_ready;
  logic [31:0]           cmd_index, cmd_length;
  logic [2:0]            cmd_size;
  logic                  unused_index_bits;

  // Fields of whichever command wins arbitration this cycle.
  assign cmd_index  = grant_wr ? dma.dma_write_ctrl_data_index  : dma.dma_read_ctrl_data_index;
  assign cmd_length = grant_wr ? dma.dma_write_ctrl_data_length : dma.dma_read_ctrl_data_length;
  assign cmd_size   = grant_wr ? dma.dma_write_ctrl_data_size   : dma.dma_read_ctrl_data_size;
  assign unused_index_bits = ^cmd_index[31:ADDR_WIDTH];

  // Occupancy next cycle: the in-flight read lands, the head may leave. A new read
  // is only issued if its slot is guaranteed when it lands, so nothing is dropped.
  assign rd_pop     = (fifo_cnt_q != 2'd0) && dma.dma_read_chnl_ready;
  assign fifo_cnt_d = fifo_cnt_q + {1'b0, inflight_q} - {1'b0, rd_pop};

  // NOTE: every signal driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    grant_rd      = 1'b0;
    grant_wr      = 1'b0;
    rd_issue      = 1'b0;
    wr_fire       = 1'b0;
    wr_chnl_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        // rst gates the combinational grants so ctrl_ready stays low during reset.
        if (rst) begin
          grant_rd = dma.dma_read_ctrl_valid && (!dma.dma_write_ctrl_valid || last_wr_q);
          grant_wr = dma.dma_write_ctrl_valid && !grant_rd;
          if (grant_rd)      state_d = RD_BURST;
          else if (grant_wr) state_d = WR_BURST;
        end
      end
      RD_BURST: begin
        rd_issue = (rem_q != 32'd0) && (fifo_cnt_d < 2'd2);
        if ((rem_q == 32'd0) && !inflight_q && (fifo_cnt_d == 2'd0)) state_d = IDLE;
      end
      WR_BURST: begin
        wr_chnl_ready = (rem_q != 32'd0);
        wr_fire       = wr_chnl_ready && dma.dma_write_chnl_valid;
        if ((rem_q == 32'd0) || (wr_fire && (rem_q == 32'd1))) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dma.dma_read_ctrl_ready  = grant_rd;
  assign dma.dma_write_ctrl_ready = grant_wr;
  assign dma.dma_read_chnl_valid  = (fifo_cnt_q != 2'd0);
  assign dma.dma_read_chnl_data   = fifo_q[rd_ptr_q];
  assign dma.dma_write_chnl_ready = wr_chnl_ready;

  // Reads and writes live in mutually exclusive states, so the port sees one access per cycle.
  assign mem_req   = rd_issue | wr_fire;
  assign mem_we    = wr_fire;
  assign mem_addr  = mem_req ? addr_q : '0;
  assign mem_wdata = wr_fire ? dma.dma_write_chnl_data : '0;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      last_wr_q  <= 1'b1;
      addr_q     <= '0;
      rem_q      <= '0;
      size_err_o <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_rd || grant_wr) begin
        last_wr_q <= grant_wr;
        addr_q    <= cmd_index[ADDR_WIDTH-1:0];
        rem_q     <= cmd_length;
        if (cmd_size != SIZE_WORD) size_err_o <= 1'b1;
      end else if (rd_issue || wr_fire) begin
        addr_q <= addr_q + 1'b1;
        rem_q  <= rem_q - 32'd1;
      end
    end
  end

  // NOTE: the FIFO storage is reset too, because the read data output must read
  // zero after reset; a larger RAM-style buffer would normally be left unreset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= rd_issue;
      fifo_cnt_q <= fifo_cnt_d;
      if (inflight_q) begin
        fifo_q[wr_ptr_q] <= mem_rdata;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (rd_pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

endmodule

// File: tb/tb_esp_dma32_mem_responder.sv
// Scoreboard bench for esp_dma32_mem_responder: commands push expected beats and
// memory writes into queues; a negedge monitor pops and compares what the DUT presents.
`timescale 1ns/1ps
module tb_esp_dma32_mem_responder;
  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_req, mem_we, size_err_o;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  esp_dma32_mem_responder_if #(.DATA_WIDTH(DW)) dma_if ();

  esp_dma32_mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .dma        (dma_if.slave),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .size_err_o (size_err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment SRAM with 1-cycle read latency.
  logic [DW-1:0] sram [DEPTH];
  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= sram[mem_addr];
    end
  end

  // Reference model: memory contents as the command stream says they should be.
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_rd [$];
  wr_t           exp_wr [$];

  int n_cmp = 0, n_bad = 0;
  int n_rd_req = 0, n_wr_req = 0, n_rd_beats = 0, outstanding = 0;
  int first_valid_cyc = -1;
  bit arm_first = 1'b0;
  int rdy_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input int act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: observed %0d (cycle %0d)", name, act, cyc);
  endtask

  // Read-channel ready: 0 always, 1 random, 2 pattern 1,0,0,1, 3 stalled.
  initial begin
    logic [3:0] pat;
    int         pi;
    pat = 4'b1001;
    pi  = 0;
    dma_if.dma_read_chnl_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       dma_if.dma_read_chnl_ready = 1'b1;
        1:       dma_if.dma_read_chnl_ready = 1'($urandom_range(0, 1));
        2:       begin dma_if.dma_read_chnl_ready = pat[pi % 4]; pi++; end
        default: dma_if.dma_read_chnl_ready = 1'b0;
      endcase
    end
  end

  // Monitor / scoreboard.
  bit            prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;
  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      prev_hold = 1'b0;
    end else begin
      if (dma_if.dma_read_ctrl_valid && dma_if.dma_write_ctrl_valid)
        check("ctrl_ready_exclusive",
              64'(dma_if.dma_read_ctrl_ready & dma_if.dma_write_ctrl_ready), 64'd0);
      if (prev_hold) begin
        check("rd_hold_valid", 64'(dma_if.dma_read_chnl_valid), 64'd1);
        check("rd_hold_data", 64'(dma_if.dma_read_chnl_data), 64'(prev_data));
      end
      prev_hold = dma_if.dma_read_chnl_valid && !dma_if.dma_read_chnl_ready;
      prev_data = dma_if.dma_read_chnl_data;
      if (dma_if.dma_read_chnl_valid) begin
        if (arm_first) begin
          first_valid_cyc = cyc;
          arm_first       = 1'b0;
        end
        if (dma_if.dma_read_chnl_ready) begin
          outstanding--;
          n_rd_beats++;
          if (exp_rd.size() == 0) fail("rd_unexpected_beat", int'(dma_if.dma_read_chnl_data));
          else check("rd_data", 64'(dma_if.dma_read_chnl_data), 64'(exp_rd.pop_front()));
        end
      end
      if (mem_req && mem_we) begin
        n_wr_req++;
        if (exp_wr.size() == 0) begin
          fail("wr_unexpected", int'(mem_addr));
        end else begin
          e = exp_wr.pop_front();
          check("wr_addr", 64'(mem_addr), 64'(e.addr));
          check("wr_data", 64'(mem_wdata), 64'(e.data));
        end
      end
      if (mem_req && !mem_we) begin
        n_rd_req++;
        outstanding++;
        check("rd_outstanding_le2", 64'(outstanding <= 2), 64'd1);
      end
    end
  end

  task automatic rd_cmd(input logic [31:0] idx, input logic [31:0] len,
                        input logic [2:0] size, output int t_hs);
    int n;
    dma_if.dma_read_ctrl_data_index  = idx;
    dma_if.dma_read_ctrl_data_length = len;
    dma_if.dma_read_ctrl_data_size   = size;
    dma_if.dma_read_ctrl_valid       = 1'b1;
    t_hs = -1;
    n    = 0;
    while (t_hs < 0 && n < 400) begin
      @(negedge clk);
      if (rst && dma_if.dma_read_ctrl_ready) begin
        t_hs = cyc;
        for (int i = 0; i < int'(len); i++) exp_rd.push_back(ref_mem[AW'(idx + 32'(i))]);
        arm_first = 1'b1;
      end
      n++;
    end
    if (t_hs < 0) fail("rd_ctrl_timeout", n);
    @(posedge clk);
    #1;
    dma_if.dma_read_ctrl_valid = 1'b0;
  endtask

  task automatic wr_cmd(input logic [31:0] idx, input logic [31:0] len, input logic [2:0] size,
                        input bit seq_data, input int gap_max, output int t_hs);
    int            n;
    bit            got;
    logic [DW-1:0] d;
    logic [DW-1:0] beats [$];
    dma_if.dma_write_ctrl_data_index  = idx;
    dma_if.dma_write_ctrl_data_length = len;
    dma_if.dma_write_ctrl_data_size   = size;
    dma_if.dma_write_ctrl_valid       = 1'b1;
    t_hs = -1;
    n    = 0;
    while (t_hs < 0 && n < 400) begin
      @(negedge clk);
      if (rst && dma_if.dma_write_ctrl_ready) begin
        t_hs = cyc;
        for (int i = 0; i < int'(len); i++) begin
          d = seq_data ? DW'(i + 1) : $urandom;
          beats.push_back(d);
          ref_mem[AW'(idx + 32'(i))] = d;
          exp_wr.push_back('{addr: AW'(idx + 32'(i)), data: d});
        end
      end
      n++;
    end
    if (t_hs < 0) fail("wr_ctrl_timeout", n);
    @(posedge clk);
    #1;
    dma_if.dma_write_ctrl_valid = 1'b0;
    for (int i = 0; i < beats.size(); i++) begin
      repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      dma_if.dma_write_chnl_valid = 1'b1;
      dma_if.dma_write_chnl_data  = beats[i];
      got = 1'b0;
      n   = 0;
      while (!got && n < 100) begin
        @(negedge clk);
        got = dma_if.dma_write_chnl_ready;
        n++;
      end
      @(posedge clk);
      #1;
      dma_if.dma_write_chnl_valid = 1'b0;
      if (!got) begin
        fail("wr_chnl_timeout", i);
        break;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_rd.size() != 0 || exp_wr.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) fail("drain_timeout", exp_rd.size() + exp_wr.size());
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rd_ctrl_ready"}, 64'(dma_if.dma_read_ctrl_ready), 64'd0);
    check({tag, "_wr_ctrl_ready"}, 64'(dma_if.dma_write_ctrl_ready), 64'd0);
    check({tag, "_rd_chnl_valid"}, 64'(dma_if.dma_read_chnl_valid), 64'd0);
    check({tag, "_rd_chnl_data"}, 64'(dma_if.dma_read_chnl_data), 64'd0);
    check({tag, "_wr_chnl_ready"}, 64'(dma_if.dma_write_chnl_ready), 64'd0);
    check({tag, "_mem_req"}, 64'(mem_req), 64'd0);
    check({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    check({tag, "_size_err"}, 64'(size_err_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t_rd, t_wr, t1, t2, t0, base_rd, base_wr, base_beats;
    dma_if.dma_read_ctrl_valid  = 1'b0;
    dma_if.dma_write_ctrl_valid = 1'b0;
    dma_if.dma_write_chnl_valid = 1'b0;
    dma_if.dma_write_chnl_data  = '0;
    dma_if.dma_read_ctrl_data_index   = '0;
    dma_if.dma_read_ctrl_data_length  = '0;
    dma_if.dma_read_ctrl_data_size    = 3'b010;
    dma_if.dma_write_ctrl_data_index  = '0;
    dma_if.dma_write_ctrl_data_length = '0;
    dma_if.dma_write_ctrl_data_size   = 3'b010;
    for (int i = 0; i < DEPTH; i++) begin
      sram[i]    = $urandom;
      ref_mem[i] = sram[i];
    end
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Tie from reset: both commands pending while still in reset; read must win first.
    fork
      rd_cmd(32'h10, 32'd3, 3'b010, t_rd);
      wr_cmd(32'h40, 32'd3, 3'b010, 1'b0, 1, t_wr);
      begin
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
      end
    join
    check("tie1_read_first", 64'(t_rd < t_wr), 64'd1);
    drain();
    // Last served was write, so a second tie again goes to the read.
    fork
      rd_cmd(32'h80, 32'd2, 3'b010, t_rd);
      wr_cmd(32'hC0, 32'd2, 3'b010, 1'b0, 0, t_wr);
    join
    check("tie2_read_first", 64'(t_rd < t_wr), 64'd1);
    drain();
    // After a lone read, a tie goes to the write.
    rd_cmd(32'h20, 32'd1, 3'b010, t1);
    drain();
    fork
      rd_cmd(32'h90, 32'd2, 3'b010, t_rd);
      wr_cmd(32'hD0, 32'd2, 3'b010, 1'b0, 0, t_wr);
    join
    check("tie3_write_first", 64'(t_wr < t_rd), 64'd1);
    drain();

    // Single read latency and back-to-back command acceptance.
    sram[5]    = 32'hDEADBEEF;
    ref_mem[5] = 32'hDEADBEEF;
    base_rd    = n_rd_req;
    rd_cmd(32'd5, 32'd1, 3'b010, t1);
    rd_cmd(32'h77, 32'd1, 3'b010, t2);
    check("single_rd_valid_latency", 64'(first_valid_cyc - t1), 64'd3);
    check("next_ctrl_after_idle", 64'(t2 - t1), 64'd4);
    drain();
    check("single_rd_mem_reqs", 64'(n_rd_req - base_rd), 64'd2);

    // Write burst wrapping at the top of memory, data 1..4.
    base_rd = n_rd_req;
    base_wr = n_wr_req;
    wr_cmd(32'(DEPTH - 2), 32'd4, 3'b010, 1'b1, 0, t1);
    drain();
    check("wr_burst_no_reads", 64'(n_rd_req - base_rd), 64'd0);
    check("wr_burst_writes", 64'(n_wr_req - base_wr), 64'd4);
    rd_cmd(32'(DEPTH - 2), 32'd4, 3'b010, t1);
    drain();

    // Length-8 read under 1,0,0,1 backpressure.
    rdy_mode   = 2;
    base_beats = n_rd_beats;
    rd_cmd(32'h300, 32'd8, 3'b010, t1);
    drain();
    check("rd8_beats", 64'(n_rd_beats - base_beats), 64'd8);
    rdy_mode = 0;

    // Zero-length write with a bad size: accepted at once, no traffic, sticky error.
    base_rd = n_rd_req;
    base_wr = n_wr_req;
    t0      = cyc;
    wr_cmd(32'h123, 32'd0, 3'b000, 1'b0, 0, t1);
    repeat (3) @(posedge clk);
    #1;
    check("len0_accept_cycle", 64'(t1 - t0), 64'd0);
    check("len0_no_mem_req", 64'((n_rd_req - base_rd) + (n_wr_req - base_wr)), 64'd0);
    check("size_err_set", 64'(size_err_o), 64'd1);
    rd_cmd(32'h200, 32'd2, 3'b010, t1);
    drain();
    check("size_err_sticky", 64'(size_err_o), 64'd1);

    // Asynchronous reset while the read FIFO is full.
    rdy_mode = 3;
    rd_cmd(32'h180, 32'd8, 3'b010, t1);
    repeat (6) @(posedge clk);
    #1;
    check("fifo_full_before_reset", 64'(dma_if.dma_read_chnl_valid), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_vals("async_reset");
    exp_rd.delete();
    outstanding = 0;
    arm_first   = 1'b0;
    rdy_mode    = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    rd_cmd(32'h2A5, 32'd1, 3'b010, t1);
    drain();
    check("post_reset_rd_latency", 64'(first_valid_cyc - t1), 64'd3);

    // Randomized command stream against the reference memory.
    for (int k = 0; k < 30; k++) begin
      rdy_mode = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1)
        wr_cmd($urandom, 32'($urandom_range(0, 6)), 3'b010, 1'b0, 2, t1);
      else
        rd_cmd($urandom, 32'($urandom_range(0, 6)), 3'b010, t1);
      drain();
    end
    rdy_mode = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/esp_dma32_mem_responder.md
# esp_dma32_mem_responder

ESP DMA target that consumes the read/write control and data channels produced by the OBI-to-ESP DMA bridge. It services each transaction against a word-addressed SRAM port with 1-cycle read latency. The block sits directly downstream of the bridge and stands in for the ESP tile's memory side: in simulation it backs a behavioural SRAM, in FPGA builds a BRAM. Bursts of any length are supported, so future burst-capable bridges work unchanged.

## Interface
- DATA_WIDTH, 32: DMA beat and memory word width; only 32 is supported.
- ADDR_WIDTH, 10: memory word-address width; depth is 2^ADDR_WIDTH words.
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  reset; asynchronous, active-low.
- dma_read_ctrl_valid / dma_read_ctrl_ready  in / out  1 / 1  read command handshake.
- dma_read_ctrl_data_index  in  32  start word index.
- dma_read_ctrl_data_length  in  32  beat count.
- dma_read_ctrl_data_size  in  3  beat size; 3'b010 is word.
- dma_read_chnl_valid / dma_read_chnl_ready  out / in  1 / 1  read data handshake.
- dma_read_chnl_data  out  DATA_WIDTH  read beat.
- dma_write_ctrl_valid / _ready, _data_index, _data_length, _data_size: same as read control, for writes.
- dma_write_chnl_valid / dma_write_chnl_ready  in / out  1 / 1  write data handshake.
- dma_write_chnl_data  in  DATA_WIDTH  write beat.
- mem_req  out  1  memory access strobe.
- mem_we  out  1  1 means write.
- mem_addr  out  ADDR_WIDTH  word address.
- mem_wdata  out  DATA_WIDTH  write data.
- mem_rdata  in  DATA_WIDTH  read data, valid the cycle after a read mem_req.
- size_err_o  out  1  sticky flag: a command arrived with size != 3'b010.

## Operation
- FSM states:
  - IDLE: arbitrates between read and write commands.
  - RD_BURST: issues memory reads and drains the read FIFO.
  - WR_BURST: accepts write beats and writes memory.
- Arbitration in IDLE:
  - Only one ctrl_valid high: that command is granted and its ctrl_ready = 1 combinationally that cycle.
  - Both high: round-robin; grant the type not served last. The last-served register resets to "write", so the first tie goes to the read.
  - ctrl_ready is 0 outside IDLE and 0 for the losing channel.
- On a ctrl handshake, latch:
  - addr_q = index[ADDR_WIDTH-1:0], so upper index bits are ignored (modulo addressing).
  - rem_q = length (32-bit).
  - size_err_o is set if size != 3'b010. The command is still executed as words. size_err_o clears only on reset.
- length == 0: the command is accepted and the FSM returns to IDLE next cycle with no beats and no mem_req.
- RD_BURST:
  - A 2-entry read FIFO feeds dma_read_chnl_*; dma_read_chnl_valid = FIFO non-empty, and data comes from the FIFO head.
  - A read is issued (mem_req=1, mem_we=0, mem_addr=addr_q) when rem_q != 0 and (FIFO occupancy + in-flight reads) < 2.
  - Each issued read: addr_q wraps at 2^ADDR_WIDTH, rem_q decrements.
  - mem_rdata is pushed the cycle after issue.
  - Exit to IDLE when rem_q == 0, nothing is in flight, and the FIFO is empty after a pop that cycle.
- WR_BURST:
  - dma_write_chnl_ready = 1 while rem_q != 0.
  - Each handshake drives, in the same cycle: mem_req=1, mem_we=1, mem_addr=addr_q, mem_wdata=dma_write_chnl_data. addr_q increments (wrapping), rem_q decrements.
  - After the final beat's handshake, return to IDLE next cycle.
- Memory-side ordering: a read issue and a write never occur in the same cycle, so the memory port is used by one access per cycle.

## Timing
- Reset values: state IDLE, all ctrl_ready 0, dma_read_chnl_valid 0, dma_read_chnl_data 0, dma_write_chnl_ready 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, size_err_o 0, FIFO empty, last-served = write.
- Reset mid-burst: everything returns to these values immediately. The FIFO is flushed, in-flight data is discarded, and the remaining beats are dropped.
- Read latency: with the ctrl handshake at cycle T, first mem_req is at T+1, FIFO push at T+2, and dma_read_chnl_valid is high from T+3.
- Read throughput: 1 beat/cycle when dma_read_chnl_ready is held high.
- Read backpressure: at most 2 reads are outstanding, so no data is ever lost. A beat holds valid and data stable until ready.
- Write latency: mem write is issued in the handshake cycle; 1 beat/cycle max.
- Back-to-back commands: the next ctrl_ready is available no earlier than the cycle after the FSM re-enters IDLE.

## Test plan
- Single read, index 5, length 1, mem[5]=32'hDEADBEEF, chnl_ready=1 -> dma_read_chnl_valid at T+3 with 32'hDEADBEEF; one mem_req; IDLE at T+4.
- Write burst, index 2^ADDR_WIDTH-2, length 4, data 1..4 -> mem_addr sequence 1022, 1023, 0, 1 carrying data 1, 2, 3, 4; FSM back in IDLE; no read traffic.
- Read burst of length 8 with chnl_ready toggling 1,0,0,1 -> all 8 words delivered in order, no duplicates; mem reads never exceed 2 outstanding.
- Read and write ctrl_valid both high from reset, twice in a row -> read granted first, then write; ctrl_ready is never high for both in one cycle.
- Write command with length 0 and size 3'b000 -> accepted in one cycle, no mem_req, size_err_o = 1 and stays high through the next normal command.
- rst low during a read burst with a full FIFO -> outputs take reset values asynchronously. A subsequent length-1 read returns the correct word with T+3 latency.
